// File: rtl/execute_cycle_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the RV32I execute stage.
// master drives the decoded instruction and forwarding selects; slave is the EX stage.
interface execute_cycle_if;
  logic        RegWriteE;
  logic        ALUSrcE;
  logic        MemWriteE;
  logic        ResultSrcE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] Imm_Ext_E;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E;
  logic [1:0]  ForwardB_E;
  logic [31:0] ResultW;

  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic [15:0] BranchCount;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardA_E, ForwardB_E, ResultW,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M, BranchCount
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E,
           ForwardA_E, ForwardB_E, ResultW,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
           ALU_ResultM, WriteDataM, PCPlus4M, BranchCount
  );
endinterface

// File: rtl/execute_cycle.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution, EX/MEM register
// and a wrapping debug counter of taken branches.
module execute_cycle (
  input logic            clk,
  input logic            rst,
  execute_cycle_if.slave ex
);
  logic        reg_write_reg;
  logic        mem_write_reg;
  logic        result_src_reg;
  logic [4:0]  rd_reg;
  logic [31:0] alu_result_reg;
  logic [31:0] write_data_reg;
  logic [31:0] pc_plus4_reg;
  logic [15:0] branch_count_reg;

  logic [31:0] fwd_src [2];
  logic [1:0]  fwd_sel [2];
  logic [31:0] fwd_val [2];
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        pc_src;

  assign fwd_src[0] = ex.RD1_E;
  assign fwd_src[1] = ex.RD2_E;
  assign fwd_sel[0] = ex.ForwardA_E;
  assign fwd_sel[1] = ex.ForwardB_E;

  // Select 10 forwards this stage's own registered result (previous instruction).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_val[gi] = (fwd_sel[gi] == 2'b01) ? ex.ResultW :
                           (fwd_sel[gi] == 2'b10) ? alu_result_reg :
                                                    fwd_src[gi];
    end
  endgenerate

  assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : fwd_val[1];

  always_comb begin
    alu_result = 32'h0;
    case (ex.ALUControlE)
      3'b000: alu_result = fwd_val[0] + src_b;
      3'b001: alu_result = fwd_val[0] - src_b;
      3'b010: alu_result = fwd_val[0] & src_b;
      3'b011: alu_result = fwd_val[0] | src_b;
      3'b101: alu_result = {31'h0, $signed(fwd_val[0]) < $signed(src_b)};
      default: alu_result = 32'h0;
    endcase
  end

  assign pc_src       = ex.BranchE & (alu_result == 32'h0);
  assign ex.PCSrcE    = pc_src;
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_reg    <= 1'b0;
      mem_write_reg    <= 1'b0;
      result_src_reg   <= 1'b0;
      rd_reg           <= 5'h0;
      alu_result_reg   <= 32'h0;
      write_data_reg   <= 32'h0;
      pc_plus4_reg     <= 32'h0;
      branch_count_reg <= 16'h0;
    end else begin
      reg_write_reg  <= ex.RegWriteE;
      mem_write_reg  <= ex.MemWriteE;
      result_src_reg <= ex.ResultSrcE;
      rd_reg         <= ex.RD_E;
      alu_result_reg <= alu_result;
      write_data_reg <= fwd_val[1];
      pc_plus4_reg   <= ex.PCPlus4E;
      if (pc_src)
        branch_count_reg <= branch_count_reg + 16'h1;
    end
  end

  assign ex.RegWriteM   = reg_write_reg;
  assign ex.MemWriteM   = mem_write_reg;
  assign ex.ResultSrcM  = result_src_reg;
  assign ex.RD_M        = rd_reg;
  assign ex.ALU_ResultM = alu_result_reg;
  assign ex.WriteDataM  = write_data_reg;
  assign ex.PCPlus4M    = pc_plus4_reg;
  assign ex.BranchCount = branch_count_reg;
endmodule

// File: tb/tb_execute_cycle.sv
// Directed-vector bench for execute_cycle with hand-computed expectations.
module tb_execute_cycle;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  execute_cycle_if bus ();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    #1;
    $display("txn %s @%0t", name, $time);
  endtask

  task automatic set_ctrl(input logic rw, input logic asrc, input logic mw, input logic rs,
                          input logic br, input logic [2:0] op);
    bus.RegWriteE   = rw;
    bus.ALUSrcE     = asrc;
    bus.MemWriteE   = mw;
    bus.ResultSrcE  = rs;
    bus.BranchE     = br;
    bus.ALUControlE = op;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset with nonzero inputs, including a branch that would be taken.
    rst = 1'b1;
    set_ctrl(1, 0, 1, 1, 1, 3'b001);
    bus.RD1_E = 32'd4;  bus.RD2_E = 32'd4;  bus.Imm_Ext_E = 32'h10;
    bus.PCE = 32'h40;   bus.PCPlus4E = 32'h44; bus.RD_E = 5'd7;
    bus.ForwardA_E = 2'b00; bus.ForwardB_E = 2'b00; bus.ResultW = 32'h55;
    tick("reset0");
    tick("reset1");
    check("rst_regwrite",  {31'h0, bus.RegWriteM},  32'h0);
    check("rst_memwrite",  {31'h0, bus.MemWriteM},  32'h0);
    check("rst_resultsrc", {31'h0, bus.ResultSrcM}, 32'h0);
    check("rst_rd",        {27'h0, bus.RD_M},       32'h0);
    check("rst_alu",       bus.ALU_ResultM,         32'h0);
    check("rst_wdata",     bus.WriteDataM,          32'h0);
    check("rst_pcplus4",   bus.PCPlus4M,            32'h0);
    check("rst_bcount",    {16'h0, bus.BranchCount}, 32'h0);
    check("rst_pcsrc",     {31'h0, bus.PCSrcE},     32'h1);
    check("rst_target",    bus.PCTargetE,           32'h50);

    // addi: 5 + 3 = 8
    rst = 1'b0;
    set_ctrl(1, 1, 0, 1, 0, 3'b000);
    bus.RD1_E = 32'd5; bus.RD2_E = 32'd9; bus.Imm_Ext_E = 32'd3;
    bus.PCPlus4E = 32'h14; bus.RD_E = 5'd3;
    tick("addi");
    check("add_alu",       bus.ALU_ResultM,         32'd8);
    check("add_regwrite",  {31'h0, bus.RegWriteM},  32'h1);
    check("add_resultsrc", {31'h0, bus.ResultSrcM}, 32'h1);
    check("add_rd",        {27'h0, bus.RD_M},       32'd3);
    check("add_wdata",     bus.WriteDataM,          32'd9);
    check("add_pcplus4",   bus.PCPlus4M,            32'h14);
    check("add_bcount",    {16'h0, bus.BranchCount}, 32'h0);

    // Dependent sub forwards ALU_ResultM: 8 - 2 = 6
    set_ctrl(1, 0, 0, 0, 0, 3'b001);
    bus.ForwardA_E = 2'b10; bus.RD1_E = 32'd100; bus.RD2_E = 32'd2;
    tick("sub_fwd");
    check("sub_alu",   bus.ALU_ResultM, 32'd6);
    check("sub_wdata", bus.WriteDataM,  32'd2);

    // Signed slt and the wrapping add
    bus.ForwardA_E = 2'b00;
    set_ctrl(1, 0, 0, 0, 0, 3'b101);
    bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 32'd1;
    tick("slt");
    check("slt_neg", bus.ALU_ResultM, 32'd1);
    bus.RD1_E = 32'd1; bus.RD2_E = 32'hFFFF_FFFF;
    tick("slt_swap");
    check("slt_swap", bus.ALU_ResultM, 32'd0);
    bus.ALUControlE = 3'b011; bus.RD1_E = 32'hF0; bus.RD2_E = 32'h0F;
    tick("or");
    check("or_alu", bus.ALU_ResultM, 32'hFF);
    bus.ALUControlE = 3'b000; bus.RD1_E = 32'hFFFF_FFFF; bus.RD2_E = 32'd1;
    tick("add_wrap");
    check("add_wrap", bus.ALU_ResultM, 32'd0);

    // Taken branch: combinational outputs before the edge, count after
    set_ctrl(0, 0, 0, 0, 1, 3'b001);
    bus.RD1_E = 32'd7; bus.RD2_E = 32'd7; bus.PCE = 32'h100; bus.Imm_Ext_E = 32'hFFFF_FFF8;
    #1;
    check("br_pcsrc",  {31'h0, bus.PCSrcE}, 32'h1);
    check("br_target", bus.PCTargetE,       32'hF8);
    tick("beq_taken");
    check("br_count1", {16'h0, bus.BranchCount}, 32'h1);
    bus.RD1_E = 32'd8;
    #1;
    check("nbr_pcsrc", {31'h0, bus.PCSrcE}, 32'h0);
    tick("beq_not_taken");
    check("nbr_count", {16'h0, bus.BranchCount}, 32'h1);

    // Store data forwarded from writeback
    set_ctrl(0, 1, 1, 0, 0, 3'b000);
    bus.ForwardB_E = 2'b01; bus.ResultW = 32'hDEAD_BEEF;
    bus.RD1_E = 32'h100; bus.RD2_E = 32'h1234; bus.Imm_Ext_E = 32'h20;
    tick("store");
    check("st_wdata",    bus.WriteDataM,         32'hDEAD_BEEF);
    check("st_alu",      bus.ALU_ResultM,        32'h120);
    check("st_memwrite", {31'h0, bus.MemWriteM}, 32'h1);
    bus.ForwardB_E = 2'b00;

    // Bubble passes through
    set_ctrl(0, 0, 0, 0, 0, 3'b110);
    tick("bubble");
    check("bub_regwrite", {31'h0, bus.RegWriteM}, 32'h0);
    check("bub_memwrite", {31'h0, bus.MemWriteM}, 32'h0);
    check("bub_alu",      bus.ALU_ResultM,        32'h0);

    // Mid-stream reset, then forward select 10 sees the cleared result
    set_ctrl(1, 1, 0, 0, 0, 3'b000);
    bus.RD1_E = 32'h5; bus.Imm_Ext_E = 32'h30;
    tick("pre_reset");
    check("pre_rst_alu", bus.ALU_ResultM, 32'h35);
    rst = 1'b1;
    tick("mid_reset");
    check("mid_rst_alu", bus.ALU_ResultM, 32'h0);
    rst = 1'b0;
    bus.ForwardA_E = 2'b10; bus.RD1_E = 32'h999; bus.Imm_Ext_E = 32'h11;
    tick("fwd_after_reset");
    check("fwd_rst_alu", bus.ALU_ResultM, 32'h11);
    bus.ForwardA_E = 2'b00;

    // Counter wrap: from reset, 65536 taken branches
    rst = 1'b1;
    tick("wrap_reset");
    rst = 1'b0;
    set_ctrl(0, 0, 0, 0, 1, 3'b001);
    bus.RD1_E = 32'd0; bus.RD2_E = 32'd0;
    repeat (65535) @(posedge clk);
    #1;
    check("wrap_ffff", {16'h0, bus.BranchCount}, 32'hFFFF);
    tick("wrap_edge");
    check("wrap_zero", {16'h0, bus.BranchCount}, 32'h0);
    tick("taken_after_wrap");
    check("count_one", {16'h0, bus.BranchCount}, 32'h1);
    rst = 1'b1;
    tick("reset_with_taken");
    check("rst_taken", {16'h0, bus.BranchCount}, 32'h0);
    rst = 1'b0;
    tick("taken_post_reset");
    check("post_rst_count", {16'h0, bus.BranchCount}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
